fifo_sync_ram: RTL

Synchronous first-word-fall-through FIFO controller built around the team's inferred simple-dual-port RAM (ram_sdp).
- Manages write/read pointers, occupancy and flags.
- Sequences the RAM's 1-cycle registered read so the head word is always presented on rd_data.
- Used as the generic elastic buffer between streaming blocks (USB, UART, DMA paths) in a single clock domain.

---
 rtl/fifo_sync_ram.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: single-clock first-word-fall-through FIFO built on an
// inferred simple-dual-port RAM whose registered read port doubles as the
// head-of-queue register. Capacity is 2^AWIDTH RAM words plus the head word.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.

// Inferred simple-dual-port RAM: one write port, one registered read port.
module ram_sdp #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_ena,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_ena,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_data_reg;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_ena) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; the output holds whenever no read is issued.
    always_ff @(posedge clk) begin
        if (rd_ena) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;
endmodule

module fifo_sync_ram #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int AFULL_LVL  = (1 << AWIDTH) - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_ena,
    output logic              full,
    output logic              afull,
    output logic [DWIDTH-1:0] rd_data,
    input  logic              rd_ena,
    output logic              empty,
    output logic              aempty,
    output logic [AWIDTH:0]   level,
    output logic              ovf,
    output logic              udf,
    input  logic              err_clr
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_W  = (AWIDTH+1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] AEMPTY_W = (AWIDTH+1)'(AEMPTY_LVL);

    logic [AWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AWIDTH:0]   ram_cnt_reg, ram_cnt_next;
    logic              head_valid_reg, head_valid_next;

    logic push_acc;
    logic pop_acc;
    logic read_issue;

    // Flags come straight from registered state.
    assign full   = (ram_cnt_reg == DEPTH_W);
    assign empty  = ~head_valid_reg;
    assign level  = ram_cnt_reg + (AWIDTH+1)'(head_valid_reg);
    assign afull  = (level >= AFULL_W);
    assign aempty = (level <= AEMPTY_W);

    // Accept decisions and head prefetch: refill the head whenever it is
    // absent or being consumed this cycle and the RAM has an unread word.
    always_comb begin
        push_acc   = wr_ena & ~full;
        pop_acc    = rd_ena & head_valid_reg;
        read_issue = (ram_cnt_reg != '0) & (~head_valid_reg | pop_acc);
    end

    // Next-state computation for pointers, RAM occupancy and head flag.
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        ram_cnt_next    = ram_cnt_reg;
        head_valid_next = head_valid_reg;

        if (push_acc) begin
            wr_ptr_next = wr_ptr_reg + AWIDTH'(1);
        end
        if (read_issue) begin
            rd_ptr_next = rd_ptr_reg + AWIDTH'(1);
        end

        case ({push_acc, read_issue})
            2'b10:   ram_cnt_next = ram_cnt_reg + (AWIDTH+1)'(1);
            2'b01:   ram_cnt_next = ram_cnt_reg - (AWIDTH+1)'(1);
            default: ram_cnt_next = ram_cnt_reg;
        endcase

        if (read_issue) begin
            head_valid_next = 1'b1;
        end else if (pop_acc) begin
            head_valid_next = 1'b0;
        end
    end

    // Control state register; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ram_cnt_reg    <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            ram_cnt_reg    <= ram_cnt_next;
            head_valid_reg <= head_valid_next;
        end
    end

    // Storage; the RAM read register is the head word. Reads are gated off
    // during reset so that no state moves in the reset cycle.
    ram_sdp #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_ena  (push_acc & ~rst),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_ena  (read_issue & ~rst),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_reg;
    logic udf_reg;

    // Sticky error flags; a new error event takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (wr_ena && full) begin
                ovf_reg <= 1'b1;
            end else if (err_clr) begin
                ovf_reg <= 1'b0;
            end
            if (rd_ena && empty) begin
                udf_reg <= 1'b1;
            end else if (err_clr) begin
                udf_reg <= 1'b0;
            end
        end
    end

    assign ovf = ovf_reg;
    assign udf = udf_reg;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf            = 1'b0;
    assign udf            = 1'b0;
`endif
endmodule
